// File: rtl/fp_normalize_sequencer_if.sv
// Handshake bundle between the adder core, the normalizer and the rounding stage.
interface fp_normalize_sequencer_if #(
    parameter int unsigned MANT_WIDTH = 24,
    parameter int unsigned EXP_WIDTH  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [MANT_WIDTH-1:0] in_mant;
    logic [EXP_WIDTH-1:0]  in_exp;
    logic                  out_valid;
    logic                  out_ready;
    logic [MANT_WIDTH-1:0] out_mant;
    logic [EXP_WIDTH-1:0]  out_exp;
    logic                  out_zero;
    logic                  out_uflow;
    logic                  busy;

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, busy
    );

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, busy
    );
endinterface

// File: rtl/fp_normalize_sequencer.sv
// Multi-cycle mantissa normalizer: leading-one scan, clamped left shift, exponent adjust.
// Define FP_NORM_FULL_LOD_EN to use one full-width leading-one detector (single scan cycle).
module fp_normalize_sequencer #(
    parameter int unsigned MANT_WIDTH = 24,
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned CHUNK      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    fp_normalize_sequencer_if.slave  bus
);
    localparam int unsigned NCHUNK = MANT_WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned LZW    = (MANT_WIDTH > 1) ? $clog2(MANT_WIDTH) : 1;
    localparam int unsigned CPW    = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [MANT_WIDTH-1:0] mant_q, mant_d;
    logic [EXP_WIDTH-1:0]  exp_q, exp_d;
    logic [LZW-1:0]        lz_q, lz_d;
    logic [MANT_WIDTH-1:0] out_mant_q, out_mant_d;
    logic [EXP_WIDTH-1:0]  out_exp_q, out_exp_d;
    logic                  out_zero_q, out_zero_d;
    logic                  out_uflow_q, out_uflow_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    int unsigned           lz_u_c, exp_u_c, sh_c;

`ifdef FP_NORM_FULL_LOD_EN
    logic [LZW-1:0]        lead_c;

    // Full-width detector: highest set bit of the whole mantissa
    always_comb begin
        lead_c = '0;
        for (int i = 0; i < int'(MANT_WIDTH); i++) begin
            if (mant_q[i]) lead_c = LZW'(i);
        end
    end
`else
    logic [KW-1:0]         k_q, k_d;
    logic [MANT_WIDTH-1:0] aligned_c;
    logic [CHUNK-1:0]      slice_c;
    logic [CPW-1:0]        lead_c;
    logic                  hit_c;

    // Shared narrow detector on slice k, counted from the MSB end
    always_comb begin
        aligned_c = mant_q << (32'(k_q) * CHUNK);
        slice_c   = aligned_c[MANT_WIDTH-1 -: CHUNK];
        lead_c    = '0;
        hit_c     = 1'b0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (slice_c[i]) begin
                lead_c = CPW'(i);
                hit_c  = 1'b1;
            end
        end
    end
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        lz_d        = lz_q;
        out_mant_d  = out_mant_q;
        out_exp_d   = out_exp_q;
        out_zero_d  = out_zero_q;
        out_uflow_d = out_uflow_q;
        out_valid_d = out_valid_q;
`ifndef FP_NORM_FULL_LOD_EN
        k_d         = k_q;
`endif
        lz_u_c      = 32'(lz_q);
        exp_u_c     = 32'(exp_q);
        sh_c        = (lz_u_c < exp_u_c) ? lz_u_c : exp_u_c;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    mant_d      = bus.in_mant;
                    exp_d       = bus.in_exp;
                    out_zero_d  = 1'b0;
                    out_uflow_d = 1'b0;
`ifndef FP_NORM_FULL_LOD_EN
                    k_d         = '0;
`endif
                    if (bus.in_mant == '0) begin
                        out_zero_d = 1'b1;
                        out_mant_d = '0;
                        out_exp_d  = '0;
                        state_d    = DONE;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
`ifdef FP_NORM_FULL_LOD_EN
                lz_d    = LZW'(MANT_WIDTH - 1 - 32'(lead_c));
                state_d = SHIFT;
`else
                if (hit_c) begin
                    lz_d    = LZW'(32'(k_q) * CHUNK + CHUNK - 1 - 32'(lead_c));
                    state_d = SHIFT;
                end else begin
                    k_d = k_q + KW'(1);
                end
`endif
            end
            SHIFT: begin
                // Shift is clamped by the exponent so it never wraps below zero
                out_mant_d  = mant_q << sh_c;
                out_exp_d   = EXP_WIDTH'(exp_u_c - sh_c);
                out_uflow_d = (lz_u_c > exp_u_c);
                state_d     = DONE;
            end
            DONE: begin
                out_valid_d = 1'b1;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mant_q      <= '0;
            exp_q       <= '0;
            lz_q        <= '0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_zero_q  <= 1'b0;
            out_uflow_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifndef FP_NORM_FULL_LOD_EN
            k_q         <= '0;
`endif
        end else begin
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            lz_q        <= lz_d;
            out_mant_q  <= out_mant_d;
            out_exp_q   <= out_exp_d;
            out_zero_q  <= out_zero_d;
            out_uflow_q <= out_uflow_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifndef FP_NORM_FULL_LOD_EN
            k_q         <= k_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_mant  = out_mant_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_uflow = out_uflow_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fp_normalize_sequencer.sv
// Scoreboard bench for fp_normalize_sequencer: reference model, latency and hold checks.
module tb_fp_normalize_sequencer;
    localparam int unsigned MW = 24;
    localparam int unsigned EW = 8;
    localparam int unsigned CW = 8;

    typedef struct {
        logic [MW-1:0] mant;
        logic [EW-1:0] exp;
        logic          zero;
        logic          uflow;
        int            lat;
        int            acc;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   n_sent = 0;
    int   n_xfer = 0;
    bit   rnd_ready = 1'b0;
    bit   seen = 1'b0;
    item_t sb[$];
    item_t cur;

    fp_normalize_sequencer_if #(.MANT_WIDTH(MW), .EXP_WIDTH(EW)) bus ();

    fp_normalize_sequencer #(.MANT_WIDTH(MW), .EXP_WIDTH(EW), .CHUNK(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference: bitwise leading-zero count, clamp by exponent
    function automatic item_t model(input logic [MW-1:0] m, input logic [EW-1:0] e);
        item_t r;
        int lz = 0;
        int sh;
        r.acc = 0;
        if (m == '0) begin
            r.mant = '0; r.exp = '0; r.zero = 1'b1; r.uflow = 1'b0; r.lat = 1;
            return r;
        end
        for (int i = int'(MW) - 1; i >= 0; i--) begin
            if (m[i]) begin
                lz = int'(MW) - 1 - i;
                break;
            end
        end
        sh      = (lz < int'(e)) ? lz : int'(e);
        r.mant  = m << sh;
        r.exp   = EW'(int'(e) - sh);
        r.zero  = 1'b0;
        r.uflow = (lz > int'(e));
`ifdef FP_NORM_FULL_LOD_EN
        r.lat   = 3;
`else
        r.lat   = lz / int'(CW) + 3;
`endif
        return r;
    endfunction

    task automatic send(input logic [MW-1:0] m, input logic [EW-1:0] e);
        item_t it;
        int t = 0;
        while (!bus.in_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_mant  = m;
        bus.in_exp   = e;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        it     = model(m, e);
        it.acc = cyc;
        sb.push_back(it);
        n_sent++;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (!(sb.size() == 0 && bus.in_ready && !bus.out_valid) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) check("drain_timeout", 32'd0, 32'd1);
    endtask

    // Output monitor: first valid cycle pops the scoreboard, later cycles check hold
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (bus.out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sb.size() == 0) begin
                        check("spurious_out", 32'd1, 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                        check("mant", 32'(bus.out_mant), 32'(cur.mant));
                        check("exp", 32'(bus.out_exp), 32'(cur.exp));
                        check("zero", 32'(bus.out_zero), 32'(cur.zero));
                        check("uflow", 32'(bus.out_uflow), 32'(cur.uflow));
                    end
                end else begin
                    check("hold_mant", 32'(bus.out_mant), 32'(cur.mant));
                    check("hold_exp", 32'(bus.out_exp), 32'(cur.exp));
                end
                check("in_ready_done", 32'(bus.in_ready), 32'd0);
                check("busy_done", 32'(bus.busy), 32'd1);
                if (bus.out_ready) n_xfer++;
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int xfer0;
        logic [MW-1:0] m;
        int pos;

        bus.in_valid  = 1'b0;
        bus.in_mant   = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_mant", 32'(bus.out_mant), 32'd0);
        check("rst_out_exp", 32'(bus.out_exp), 32'd0);
        check("rst_out_zero", 32'(bus.out_zero), 32'd0);
        check("rst_out_uflow", 32'(bus.out_uflow), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        send(24'h000001, 8'd100);
        send(24'h800000, 8'd5);
        send(24'h000100, 8'd10);
        send(24'h000000, 8'd50);
        send(24'h000010, 8'd0);
        send(24'h00FFFF, 8'd8);
        send(24'h400000, 8'd1);
        wait_drain();

        // Downstream stall of 5 cycles while the result is presented
        xfer0 = n_xfer;
        bus.out_ready = 1'b0;
        send(24'h012345, 8'd200);
        for (int t = 0; t < 50 && !bus.out_valid; t++) begin
            @(posedge clk); #1;
        end
        check("stall_valid_seen", 32'(bus.out_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_drain();
        check("stall_single_xfer", 32'(n_xfer - xfer0), 32'd1);

        // Reset while scanning: transaction must vanish
        bus.in_valid = 1'b1;
        bus.in_mant  = 24'h000001;
        bus.in_exp   = 8'd100;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_out", 32'(bus.out_valid), 32'd0);

        send(24'h000001, 8'd100);
        wait_drain();

        // Random leading-one positions, exponents and backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            pos = int'($urandom_range(0, MW - 1));
            m   = (MW'(1) << pos) | (MW'($urandom) & ((MW'(1) << pos) - MW'(1)));
            if (i % 13 == 5) m = '0;
            send(m, EW'($urandom_range(0, 255)));
        end
        wait_drain();
        rnd_ready = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);

        check("xfer_count", 32'(n_xfer), 32'(n_sent));
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
